// File: rtl/vx_commit_arb.sv
// Commit merge stage: round-robin over the execute-unit commit streams,
// with packet lock until eop and a 2-entry output FIFO.
module vx_commit_arb #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 128,
    parameter int COUNTW   = 32,
    localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       in_valid,
    input  logic [NUM_REQS*DATAW-1:0] in_data,
    input  logic [NUM_REQS-1:0]       in_sop,
    input  logic [NUM_REQS-1:0]       in_eop,
    output logic [NUM_REQS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [SELW-1:0]           out_sel,
    input  logic                      out_ready,
    output logic [COUNTW-1:0]         commit_count
);

    logic [1:0]        r_count;
    logic [SELW-1:0]   r_rr_ptr;
    logic [SELW-1:0]   r_lock_idx;
    logic              r_locked;
    logic [DATAW-1:0]  r_fifo_data [2];
    logic [1:0]        r_fifo_sop;
    logic [1:0]        r_fifo_eop;
    logic [SELW-1:0]   r_fifo_sel [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [COUNTW-1:0] r_commit_count;

    logic [SELW-1:0]   w_gnt;
    logic [SELW:0]     w_sum;
    logic              w_found;
    logic              w_gnt_vld;
    logic              w_space;
    logic              w_push;
    logic              w_pop;
    logic [DATAW-1:0]  w_gnt_data;
    logic              w_gnt_sop;
    logic              w_gnt_eop;
    logic [SELW-1:0]   w_next_rr;

    // Rotating priority scan starting at r_rr_ptr; a held packet pins the grant.
    always_comb begin
        w_gnt   = r_rr_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        if (r_locked) begin
            w_gnt = r_lock_idx;
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                w_sum = {1'b0, r_rr_ptr} + (SELW+1)'(k);
                if (w_sum >= (SELW+1)'(NUM_REQS)) begin
                    w_sum = w_sum - (SELW+1)'(NUM_REQS);
                end
                if (!w_found && in_valid[w_sum[SELW-1:0]]) begin
                    w_found = 1'b1;
                    w_gnt   = w_sum[SELW-1:0];
                end
            end
        end
    end

    assign w_gnt_vld  = in_valid[w_gnt];
    assign w_gnt_sop  = in_sop[w_gnt];
    assign w_gnt_eop  = in_eop[w_gnt];
    assign w_gnt_data = in_data[int'(w_gnt)*DATAW +: DATAW];
    assign w_space    = (r_count != 2'd2);
    assign w_push     = w_gnt_vld && w_space;
    assign w_pop      = (r_count != 2'd0) && out_ready;
    assign w_next_rr  = (int'(w_gnt) == NUM_REQS-1) ? '0 : w_gnt + 1'b1;

    always_comb begin
        in_ready = '0;
        if (w_space && !reset) begin
            in_ready[w_gnt] = 1'b1;
        end
    end

    assign out_valid    = (r_count != 2'd0) && !reset;
    assign out_data     = reset ? '0   : r_fifo_data[r_rd_ptr];
    assign out_sop      = reset ? 1'b0 : r_fifo_sop[r_rd_ptr];
    assign out_eop      = reset ? 1'b0 : r_fifo_eop[r_rd_ptr];
    assign out_sel      = reset ? '0   : r_fifo_sel[r_rd_ptr];
    assign commit_count = r_commit_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= 2'd0;
            r_rr_ptr       <= '0;
            r_locked       <= 1'b0;
            r_lock_idx     <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_commit_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_gnt_data;
                r_fifo_sop[r_wr_ptr]  <= w_gnt_sop;
                r_fifo_eop[r_wr_ptr]  <= w_gnt_eop;
                r_fifo_sel[r_wr_ptr]  <= w_gnt;
                r_wr_ptr              <= ~r_wr_ptr;
                if (w_gnt_eop) begin
                    r_locked <= 1'b0;
                    r_rr_ptr <= w_next_rr;
                end else begin
                    r_locked   <= 1'b1;
                    r_lock_idx <= w_gnt;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                if (r_fifo_eop[r_rd_ptr]) begin
                    r_commit_count <= r_commit_count + 1'b1;
                end
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed bench for vx_commit_arb: per-stream source queues drive beats,
// an expected-beat scoreboard checks the merged output stream.
module tb_vx_commit_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_sop;
    logic [N-1:0]  in_eop;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic [1:0]    out_sel;
    logic          out_ready;
    logic [CW-1:0] commit_count;

    vx_commit_arb #(.NUM_REQS(N), .DATAW(DW), .COUNTW(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_sel(out_sel),
        .out_ready(out_ready), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [1:0]    sel;
        int            gap;
    } beat_t;

    beat_t src_q [N][$];
    beat_t exp_q [$];
    int    hold [N];
    int    seq_id;
    int    n_pass, n_tot;
    int    cyc, nacc, first_acc, last_acc;
    logic [N-1:0]  s_rdy, s_vld, acc;
    logic          s_ov;
    logic [CW-1:0] exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input int s, input int nb, input int gap1, input int nexp);
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            bt.data = {4'(s), 12'(seq_id), 16'(b)};
            bt.sop  = (b == 0);
            bt.eop  = (b == nb - 1);
            bt.sel  = 2'(s);
            bt.gap  = (b == 1) ? gap1 : 0;
            src_q[s].push_back(bt);
            if (b < nexp) exp_q.push_back(bt);
        end
        seq_id++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && hold[i] == 0) begin
                in_valid[i]           = 1'b1;
                in_data[i*DW +: DW]   = src_q[i][0].data;
                in_sop[i]             = src_q[i][0].sop;
                in_eop[i]             = src_q[i][0].eop;
            end else begin
                in_valid[i]           = 1'b0;
                in_data[i*DW +: DW]   = '0;
                in_sop[i]             = 1'b0;
                in_eop[i]             = 1'b0;
            end
        end
    endtask

    task automatic step();
        beat_t e;
        @(negedge clk);
        s_rdy = in_ready;
        s_vld = in_valid;
        s_ov  = out_valid;
        acc   = in_valid & in_ready;
        if (|acc) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            nacc++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {28'd0, out_data, out_sop, out_eop, out_sel},
                            {28'd0, e.data, e.sop, e.eop, e.sel});
                if (e.eop) exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(src_q[i].pop_front());
                hold[i] = (src_q[i].size() > 0) ? src_q[i][0].gap : 0;
            end else if (hold[i] > 0) begin
                hold[i]--;
            end
        end
        drive();
    endtask

    task automatic drain(input int bound);
        int k = 0;
        int pend;
        pend = exp_q.size();
        for (int i = 0; i < N; i++) pend += src_q[i].size();
        while (pend != 0 && k < bound) begin
            step();
            k++;
            pend = exp_q.size();
            for (int i = 0; i < N; i++) pend += src_q[i].size();
        end
        chk("drain", 64'(pend), 64'd0);
        chk("cnt_model", 64'(commit_count), 64'(exp_cnt));
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            hold[i] = 0;
        end
        exp_q.delete();
        exp_cnt = '0;
    endtask

    initial begin
        int lens [10] = '{1, 2, 3, 4, 1, 2, 3, 4, 2, 1};
        n_pass = 0; n_tot = 0; cyc = 0; seq_id = 0;
        nacc = 0; first_acc = -1; last_acc = -1;
        reset = 1'b1; out_ready = 1'b1;
        clear_srcs();
        send(0, 1, 0, 1); send(1, 1, 0, 1);
        send(2, 1, 0, 1); send(3, 1, 0, 1);
        send(0, 1, 0, 1);
        drive();
        repeat (3) begin
            step();
            chk("rst_ready", 64'(s_rdy), 64'd0);
            chk("rst_valid", 64'(s_ov), 64'd0);
            chk("rst_count", 64'(commit_count), 64'd0);
        end
        reset = 1'b0;
        nacc = 0; first_acc = -1;
        drain(50);
        chk("rr_b2b", 64'(last_acc - first_acc), 64'd4);
        chk("rr_nacc", 64'(nacc), 64'd5);
        chk("rr_count", 64'(commit_count), 64'd5);

        send(1, 3, 2, 3); send(0, 1, 0, 1);
        drive();
        step();
        chk("lat_empty", 64'(s_ov), 64'd0);
        chk("lock_acc0", 64'(s_rdy & s_vld), 64'b0010);
        step();
        chk("lat_t1", 64'(s_ov), 64'd1);
        chk("lock_rdy", 64'(s_rdy), 64'b0010);
        chk("lock_vld", 64'(s_vld), 64'b0001);
        drain(50);
        chk("lock_count", 64'(commit_count), 64'd7);

        out_ready = 1'b0;
        repeat (4) send(2, 1, 0, 1);
        drive();
        nacc = 0;
        repeat (5) step();
        chk("bp_nacc", 64'(nacc), 64'd2);
        chk("bp_ready", 64'(s_rdy), 64'd0);
        chk("bp_valid", 64'(s_ov), 64'd1);
        out_ready = 1'b1;
        drain(50);
        chk("bp_count", 64'(commit_count), 64'd11);

        send(2, 4, 0, 1);
        drive();
        step();
        step();
        reset = 1'b1;
        src_q[2].delete();
        hold[2] = 0;
        exp_cnt = '0;
        drive();
        repeat (2) begin
            step();
            chk("mid_rst_ready", 64'(s_rdy), 64'd0);
            chk("mid_rst_valid", 64'(s_ov), 64'd0);
        end
        chk("mid_rst_count", 64'(commit_count), 64'd0);
        chk("mid_rst_sb", 64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        step();
        chk("post_rst_valid", 64'(s_ov), 64'd0);
        chk("post_rst_ready", 64'(s_rdy), 64'b0001);
        send(0, 1, 0, 1); send(3, 1, 0, 1);
        drive();
        drain(50);

        reset = 1'b1;
        clear_srcs();
        drive();
        repeat (2) step();
        reset = 1'b0;
        foreach (lens[j]) send(3, lens[j], 0, lens[j]);
        drive();
        drain(200);
        chk("cnt10", 64'(commit_count), 64'd10);
        repeat (5) send(1, 1, 0, 1);
        drive();
        drain(50);
        chk("cnt15", 64'(commit_count), 64'd15);
        send(2, 2, 0, 2);
        drive();
        drain(50);
        chk("cnt_wrap", 64'(commit_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
